adc_sample_framer: RTL and testbench



---
 rtl/adc_sample_framer_pkg.sv | 16 +
 rtl/adc_sample_framer_if.sv | 12 +
 rtl/adc_sample_framer_decimator.sv | 26 ++
 rtl/adc_sample_framer.sv | 131 +++++++++++++
 tb/tb_adc_sample_framer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_sample_framer_pkg.sv
// Shared types and sizing helpers for the ADC sample framer.
package adc_framer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam int OVR_W = 16;

    function automatic int words_per_sample(int nch, int cw, int dw);
        return nch * cw / dw;
    endfunction

endpackage

// File: rtl/adc_sample_framer_if.sv
// Snapshot word stream from the framer to the DMA packet builder.
interface adc_sample_framer_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tready;
    logic                  s_tlast;

    modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
    modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);
endinterface

// File: rtl/adc_sample_framer_decimator.sv
// Keeps one conversion in (ratio+1); take is combinational with the valid strobe.
module adc_decimator #(
    parameter int DECIM_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   run,
    input  logic                   valid,
    input  logic [DECIM_WIDTH-1:0] ratio,
    output logic                   take
);
    logic [DECIM_WIDTH-1:0] cnt;

    // >= so a ratio lowered below the running count fires on the next valid
    assign take = run & valid & (cnt >= ratio);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (run & valid)
            cnt <= take ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/adc_sample_framer.sv
// ADC decimating snapshot framer; ADC_TEST_PATTERN_EN adds a test_mode pattern source.
module adc_sample_framer
    import adc_framer_pkg::*;
#(
    parameter int NUM_CHANNELS = 32,
    parameter int CHAN_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int DECIM_WIDTH  = 16
) (
    input  logic                               data_clk,
    input  logic                               dma_rst_n,
    input  logic                               dma_en,
    input  logic [NUM_CHANNELS*CHAN_WIDTH-1:0] adc_data,
    input  logic                               adc_data_valid,
    input  logic [DECIM_WIDTH-1:0]             decim_ratio,
`ifdef ADC_TEST_PATTERN_EN
    input  logic                               test_mode,
`endif
    output logic                               new_sample,
    adc_sample_framer_if.master                axis,
    output logic                               overrun,
    output logic [OVR_W-1:0]                   overrun_count
);
    localparam int WORDS = words_per_sample(NUM_CHANNELS, CHAN_WIDTH, DATA_WIDTH);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t                             state;
    logic                               en_q;
    logic                               rise;
    logic                               run;
    logic                               take;
    logic                               tvalid;
    logic [IDX_W-1:0]                   idx;
    logic [WORDS-1:0][DATA_WIDTH-1:0]   snap;
    logic [NUM_CHANNELS*CHAN_WIDTH-1:0] capture;

    assign rise = dma_en & ~en_q;
    assign run  = dma_en & (state != IDLE);

    adc_decimator #(.DECIM_WIDTH(DECIM_WIDTH)) u_decim (
        .clk   (data_clk),
        .rst_n (dma_rst_n),
        .clear (rise),
        .run   (run),
        .valid (adc_data_valid),
        .ratio (decim_ratio),
        .take  (take)
    );

`ifdef ADC_TEST_PATTERN_EN
    logic [15:0] sample_count;

    always_comb begin
        capture = adc_data;
        if (test_mode)
            for (int k = 0; k < NUM_CHANNELS; k++)
                capture[k*CHAN_WIDTH +: CHAN_WIDTH] = CHAN_WIDTH'({sample_count, 16'(k)});
    end

    always_ff @(posedge data_clk) begin
        if (!dma_rst_n)
            sample_count <= '0;
        else if (dma_en && state == IDLE && rise)
            sample_count <= '0;
        else if (dma_en && state == ARMED && take)
            sample_count <= sample_count + 1'b1;
    end
`else
    assign capture = adc_data;
`endif

    assign axis.s_tdata  = snap[idx];
    assign axis.s_tvalid = tvalid;
    assign axis.s_tlast  = tvalid & (idx == LAST_IDX);

    always_ff @(posedge data_clk) begin
        if (!dma_rst_n) begin
            state         <= IDLE;
            en_q          <= 1'b0;
            tvalid        <= 1'b0;
            new_sample    <= 1'b0;
            idx           <= '0;
            snap          <= '0;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else begin
            en_q       <= dma_en;
            new_sample <= 1'b0;
            if (!dma_en) begin
                state  <= IDLE;
                tvalid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                        if (rise) begin
                            overrun       <= 1'b0;
                            overrun_count <= '0;
                        end
                    end
                    ARMED: if (take) begin
                        snap       <= capture;
                        idx        <= '0;
                        tvalid     <= 1'b1;
                        new_sample <= 1'b1;
                        state      <= SEND;
                    end
                    SEND: begin
                        if (axis.s_tready) begin
                            if (idx == LAST_IDX) begin
                                tvalid <= 1'b0;
                                idx    <= '0;
                                state  <= ARMED;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                        // a take while draining (even on the last beat) is dropped
                        if (take) begin
                            overrun <= 1'b1;
                            if (overrun_count != '1)
                                overrun_count <= overrun_count + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_sample_framer.sv
// Randomized bench for adc_sample_framer against a queue-based snapshot model.
module tb_adc_sample_framer;
    logic           data_clk = 1'b0;
    logic           dma_rst_n;
    logic           dma_en;
    logic [1023:0]  adc_data;
    logic           adc_data_valid;
    logic [15:0]    decim_ratio;
    logic           new_sample;
    logic           overrun;
    logic [15:0]    overrun_count;
`ifdef ADC_TEST_PATTERN_EN
    logic           test_mode;
`endif

    adc_sample_framer_if #(.DATA_WIDTH(64)) axis();

    adc_sample_framer dut (
        .data_clk       (data_clk),
        .dma_rst_n      (dma_rst_n),
        .dma_en         (dma_en),
        .adc_data       (adc_data),
        .adc_data_valid (adc_data_valid),
        .decim_ratio    (decim_ratio),
`ifdef ADC_TEST_PATTERN_EN
        .test_mode      (test_mode),
`endif
        .new_sample     (new_sample),
        .axis           (axis),
        .overrun        (overrun),
        .overrun_count  (overrun_count)
    );

    always #5 data_clk = ~data_clk;

    int errors = 0;
    int checks = 0;
    int n_new  = 0;

    // reference model: pending snapshot words as a queue
    bit          m_active, m_en_q, m_new, m_ovr;
    int          m_decim, m_ovr_cnt, m_samp;
    logic [63:0] m_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit          take, was_busy, tm;
        logic [31:0] ch[32];
        if (!dma_rst_n) begin
            m_active = 0; m_en_q = 0; m_new = 0; m_ovr = 0;
            m_ovr_cnt = 0; m_decim = 0; m_samp = 0;
            m_q.delete();
        end else begin
            m_new = 0;
            if (!dma_en) begin
                m_active = 0;
                m_q.delete();
            end else if (!m_active) begin
                m_active = 1;
                if (!m_en_q) begin
                    m_ovr = 0; m_ovr_cnt = 0; m_decim = 0; m_samp = 0;
                end
            end else begin
                was_busy = m_q.size() > 0;
                take = 0;
                if (adc_data_valid) begin
                    if (m_decim >= int'(decim_ratio)) begin
                        take = 1;
                        m_decim = 0;
                    end else begin
                        m_decim++;
                    end
                end
                if (was_busy && axis.s_tready) void'(m_q.pop_front());
                if (take) begin
                    if (was_busy) begin
                        m_ovr = 1;
                        if (m_ovr_cnt < 65535) m_ovr_cnt++;
                    end else begin
`ifdef ADC_TEST_PATTERN_EN
                        tm = test_mode;
`else
                        tm = 0;
`endif
                        for (int k = 0; k < 32; k++)
                            ch[k] = tm ? {m_samp[15:0], 16'(k)} : adc_data[32*k +: 32];
                        for (int i = 0; i < 16; i++)
                            m_q.push_back({ch[2*i+1], ch[2*i]});
                        m_new = 1;
                        m_samp = (m_samp + 1) % 65536;
                    end
                end
            end
            m_en_q = dma_en;
        end
    endtask

    task automatic cycle();
        @(posedge data_clk);
        model_step();
        #1;
        if (new_sample === 1'b1) n_new++;
        chk("tvalid", axis.s_tvalid, m_q.size() > 0);
        if (m_q.size() > 0) chk("tdata", axis.s_tdata, m_q[0]);
        chk("tlast", axis.s_tlast, m_q.size() == 1);
        chk("new_sample", new_sample, m_new);
        chk("overrun", overrun, m_ovr);
        chk("overrun_count", overrun_count, 64'(m_ovr_cnt));
    endtask

    task automatic rand_data();
        for (int k = 0; k < 32; k++) adc_data[32*k +: 32] = $urandom;
    endtask

    logic [63:0] saved_w0;

    initial begin
        dma_rst_n = 0; dma_en = 0; adc_data = '0; adc_data_valid = 0;
        decim_ratio = 0; axis.s_tready = 0;
`ifdef ADC_TEST_PATTERN_EN
        test_mode = 0;
`endif
        // reset held with strobes toggling
        dma_en = 1;
        repeat (4) begin
            adc_data_valid = ~adc_data_valid;
            rand_data();
            cycle();
        end
        chk("rst_tdata", axis.s_tdata, 64'h0);
        chk("rst_new", n_new, 0);

        // basic frame
        dma_rst_n = 1; adc_data_valid = 0; axis.s_tready = 1; decim_ratio = 0;
        cycle();
        for (int k = 0; k < 32; k++) adc_data[32*k +: 32] = 32'h1000 + k;
        adc_data_valid = 1;
        cycle();
        adc_data_valid = 0;
        chk("b_new", new_sample, 1);
        chk("b_w0", axis.s_tdata, 64'h00001001_00001000);
        repeat (15) cycle();
        chk("b_w15", axis.s_tdata, 64'h0000101F_0000101E);
        chk("b_tlast", axis.s_tlast, 1);
        cycle();
        chk("b_done", axis.s_tvalid, 0);

        // decimation by 4 with toggling ready
        decim_ratio = 3; n_new = 0;
        for (int v = 0; v < 8; v++) begin
            rand_data();
            adc_data_valid = 1;
            axis.s_tready = ~axis.s_tready;
            cycle();
            adc_data_valid = 0;
            repeat (11) begin
                axis.s_tready = ~axis.s_tready;
                cycle();
            end
        end
        axis.s_tready = 1;
        repeat (20) cycle();
        chk("c_snapshots", n_new, 2);

        // overrun under full backpressure
        decim_ratio = 0; axis.s_tready = 0;
        for (int v = 0; v < 3; v++) begin
            rand_data();
            if (v == 0) saved_w0 = adc_data[63:0];
            adc_data_valid = 1;
            cycle();
        end
        adc_data_valid = 0;
        chk("d_overrun", overrun, 1);
        chk("d_count", overrun_count, 2);
        chk("d_w0", axis.s_tdata, saved_w0);
        axis.s_tready = 1;
        repeat (20) cycle();

        // abort mid-frame, re-enable
        rand_data();
        adc_data_valid = 1;
        cycle();
        adc_data_valid = 0;
        repeat (5) cycle();
        dma_en = 0;
        cycle();
        chk("e_abort", axis.s_tvalid, 0);
        dma_en = 1;
        cycle();
        chk("e_count0", overrun_count, 0);
        chk("e_ovr0", overrun, 0);
        cycle();
        rand_data();
        saved_w0 = adc_data[63:0];
        adc_data_valid = 1;
        cycle();
        adc_data_valid = 0;
        chk("e_new", new_sample, 1);
        chk("e_w0", axis.s_tdata, saved_w0);
        repeat (20) cycle();

`ifdef ADC_TEST_PATTERN_EN
        dma_en = 0;
        cycle();
        dma_en = 1;
        cycle();
        cycle();
        test_mode = 1;
        for (int s = 0; s < 3; s++) begin
            adc_data_valid = 1;
            cycle();
            adc_data_valid = 0;
            cycle();
            if (s == 2) chk("t_w1", axis.s_tdata, 64'h00020003_00020002);
            repeat (18) cycle();
        end
        test_mode = 0;
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            dma_rst_n = ($urandom_range(0, 399) != 0);
            dma_en = ($urandom_range(0, 79) != 0);
            adc_data_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) decim_ratio = 16'($urandom_range(0, 3));
            axis.s_tready = ($urandom_range(0, 2) != 0);
`ifdef ADC_TEST_PATTERN_EN
            test_mode = ($urandom_range(0, 3) == 0);
`endif
            rand_data();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
